// File: rtl/uart_transmitter.sv
// Serial frame transmitter: start, 8 data bits LSB first, optional parity, stop.
// TxD and Tx_BUSY come straight from flops; one write accepted per idle period.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic            wrap;

  assign wrap    = (baud_q == BAUD_LAST);
  assign TxD     = txd_q;
  assign Tx_BUSY = busy_q;

  // txd_d always carries the level of the state being entered
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    if (state_q != S_IDLE) begin
      baud_d = wrap ? '0 : baud_q + 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (Tx_EN && Tx_WR) begin
          state_d = S_START;
          shift_d = Tx_DATA;
          par_d   = (^Tx_DATA) ^ PARITY_ODD;
          baud_d  = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (wrap) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (wrap) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            if (PARITY_EN) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (wrap) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (wrap) begin
          state_d = S_IDLE;
          bit_d   = '0;
          txd_d   = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances cover even parity,
// odd parity and no-parity framing at 4 clocks per bit.
module tb_uart_transmitter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       wr;
  logic [7:0] data;
  logic       txd_a, busy_a;
  logic       txd_o, busy_o;
  logic       txd_n, busy_n;
  int         checks;
  int         errors;

  uart_transmitter #(
    .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .Tx_EN(en), .Tx_WR(wr),
    .Tx_DATA(data), .TxD(txd_a), .Tx_BUSY(busy_a)
  );

  uart_transmitter #(
    .CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)
  ) dut_odd (
    .clk(clk), .reset(reset), .Tx_EN(en), .Tx_WR(wr),
    .Tx_DATA(data), .TxD(txd_o), .Tx_BUSY(busy_o)
  );

  uart_transmitter #(
    .CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)
  ) dut_np (
    .clk(clk), .reset(reset), .Tx_EN(en), .Tx_WR(wr),
    .Tx_DATA(data), .TxD(txd_n), .Tx_BUSY(busy_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wr    = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    logic [10:0] seq;
    seq = 11'b10101001010;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_init txd=%b busy=%b exp 1/0", txd_a, busy_a);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    data = 8'hA5;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (txd_a !== seq[2] || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre txd=%b busy=%b exp %b/1", txd_a, busy_a, seq[2]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_async txd=%b busy=%b exp 1/0", txd_a, busy_a);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d txd=%b busy=%b exp 1/0", c, txd_a, busy_a);
      end
    end
  endtask

  task automatic test_single();
    logic [10:0] seq;
    seq  = 11'b10101001010;
    data = 8'hA5;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (txd_a !== seq[c/4] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL single cyc %0d txd=%b busy=%b exp %b/1", c, txd_a, busy_a, seq[c/4]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL single_end txd=%b busy=%b exp 1/0", txd_a, busy_a);
    end
  endtask

  task automatic test_parity();
    logic [10:0] seq_o;
    logic [9:0]  seq_n;
    seq_o = 11'b10000000010;
    seq_n = 10'b1000000010;
    data  = 8'h01;
    wr    = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (txd_o !== seq_o[c/4] || busy_o !== 1'b1) begin
        errors++;
        $display("FAIL odd cyc %0d txd=%b busy=%b exp %b/1", c, txd_o, busy_o, seq_o[c/4]);
      end
      checks++;
      if (c < 40) begin
        if (txd_n !== seq_n[c/4] || busy_n !== 1'b1) begin
          errors++;
          $display("FAIL nopar cyc %0d txd=%b busy=%b exp %b/1", c, txd_n, busy_n, seq_n[c/4]);
        end
      end else begin
        if (txd_n !== 1'b1 || busy_n !== 1'b0) begin
          errors++;
          $display("FAIL nopar_end cyc %0d txd=%b busy=%b exp 1/0", c, txd_n, busy_n);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (txd_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL odd_end txd=%b busy=%b exp 1/0", txd_o, busy_o);
    end
  endtask

  task automatic test_write_busy();
    logic [10:0] seq;
    seq  = 11'b10001111000;
    data = 8'h3C;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (txd_a !== seq[c/4] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL wbusy cyc %0d txd=%b busy=%b exp %b/1", c, txd_a, busy_a, seq[c/4]);
      end
      wr   = (c == 9);
      data = (c == 9) ? 8'hFF : 8'h3C;
      @(posedge clk);
      #1;
    end
    wr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL wbusy_idle cyc %0d txd=%b busy=%b exp 1/0", c, txd_a, busy_a);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] seq;
    seq  = 11'b10010101010;
    data = 8'h3C;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 44; c++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap txd=%b busy=%b exp 1/0", txd_a, busy_a);
    end
    data = 8'h55;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (txd_a !== seq[c/4] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL b2b cyc %0d txd=%b busy=%b exp %b/1", c, txd_a, busy_a, seq[c/4]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end txd=%b busy=%b exp 1/0", txd_a, busy_a);
    end
  endtask

  task automatic test_enable();
    logic [10:0] seq;
    seq  = 11'b10110000110;
    en   = 1'b0;
    data = 8'hAA;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL en_off cyc %0d txd=%b busy=%b exp 1/0", c, txd_a, busy_a);
      end
      @(posedge clk);
      #1;
    end
    en   = 1'b1;
    data = 8'hC3;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 44; c++) begin
      checks++;
      if (txd_a !== seq[c/4] || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL en_drop cyc %0d txd=%b busy=%b exp %b/1", c, txd_a, busy_a, seq[c/4]);
      end
      if (c == 4) en = 1'b0;
      @(posedge clk);
      #1;
    end
    data = 8'h00;
    wr   = 1'b1;
    @(posedge clk);
    #1 wr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (txd_a !== 1'b1 || busy_a !== 1'b0) begin
        errors++;
        $display("FAIL en_drop_idle cyc %0d txd=%b busy=%b exp 1/0", c, txd_a, busy_a);
      end
      @(posedge clk);
      #1;
    end
    en = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    en     = 1'b1;
    wr     = 1'b0;
    data   = 8'h00;
    test_reset();
    do_reset();
    test_single();
    do_reset();
    test_parity();
    do_reset();
    test_write_busy();
    do_reset();
    test_back_to_back();
    do_reset();
    test_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
